// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART blocks.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } uart_tx_state_t;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  function automatic int clks_per_bit(input int freq, input int baud);
    return freq / baud;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: counts 0..CLKS_PER_BIT-1 and flags the last cycle of each bit.
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/rv_uart_tx.sv
// UART transmitter draining a ready/valid byte stream onto a single idle-high line.
//
// state  | meaning
// IDLE   | line high, in_rdy asserted, waiting for a transfer
// START  | start bit (low) for one bit period
// DATA   | data bits, LSB first, one bit period each
// PARITY | parity bit (only when parity is enabled)
// STOP   | stop bit(s), line high
module rv_uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD_RATE   = 115_200,
  parameter int DATA_WIDTH  = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_val,
  output logic                  in_rdy,
  output logic                  tx,
  output logic                  busy
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ_HZ, BAUD_RATE);
  localparam int BW = 4;
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH - 1);
  localparam logic LAST_STOP = 1'(STOP_BITS - 1);

  if (CLKS_PER_BIT < 2) begin : g_bad_baud
    $error("rv_uart_tx: CLKS_PER_BIT must be at least 2");
  end
  if (PARITY_MODE != PARITY_NONE && PARITY_MODE != PARITY_EVEN && PARITY_MODE != PARITY_ODD) begin : g_bad_parity
    $error("rv_uart_tx: illegal PARITY_MODE");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("rv_uart_tx: STOP_BITS must be 1 or 2");
  end
  if (DATA_WIDTH < 5 || DATA_WIDTH > 9) begin : g_bad_width
    $error("rv_uart_tx: DATA_WIDTH must be 5..9");
  end

  uart_tx_state_t        state, state_d;
  logic [BW-1:0]         bit_cnt;
  logic                  stop_cnt;
  logic [DATA_WIDTH-1:0] shreg;
  logic                  par_bit;
  logic                  tx_q, tx_d;
  logic                  tick;
  logic                  xfer;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk  (clk),
    .rst  (rst),
    .clear(state == IDLE),
    .tick (tick)
  );

  assign in_rdy = (state == IDLE) && !rst;
  assign xfer   = in_rdy && in_val;
  assign busy   = (state != IDLE);
  assign tx     = tx_q;

  always_comb begin
    state_d = state;
    tx_d    = 1'b1;
    case (state)
      IDLE: begin
        if (in_val) state_d = START;
      end
      START: begin
        tx_d = 1'b0;
        if (tick) state_d = DATA;
      end
      DATA: begin
        tx_d = shreg[0];
        if (tick && bit_cnt == LAST_BIT) begin
          state_d = (PARITY_MODE != PARITY_NONE) ? PARITY : STOP;
        end
      end
      PARITY: begin
        tx_d = par_bit;
        if (tick) state_d = STOP;
      end
      STOP: begin
        if (tick && stop_cnt == LAST_STOP) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // tx is registered from the current state, so the line lags state by one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      bit_cnt  <= '0;
      stop_cnt <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state <= state_d;
      tx_q  <= tx_d;
      if (state == DATA && tick) begin
        bit_cnt <= (bit_cnt == LAST_BIT) ? '0 : bit_cnt + 1'b1;
      end
      if (state == STOP && tick) begin
        stop_cnt <= (stop_cnt == LAST_STOP) ? 1'b0 : stop_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (xfer) begin
      shreg   <= in_data;
      par_bit <= (PARITY_MODE == PARITY_ODD) ? ~(^in_data) : (^in_data);
    end else if (state == DATA && tick) begin
      shreg <= {1'b0, shreg[DATA_WIDTH-1:1]};
    end
  end

endmodule

// File: tb/tb_rv_uart_tx.sv
// Self-checking bench for rv_uart_tx against a frame-level line model.
module tb_rv_uart_tx;

  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] in_data_a = 8'h00, in_data_b = 8'h00, in_data_c = 8'h00;
  logic       in_val_a = 1'b0, in_val_b = 1'b0, in_val_c = 1'b0;
  logic       in_rdy_a, in_rdy_b, in_rdy_c;
  logic       tx_a, tx_b, tx_c;
  logic       busy_a, busy_b, busy_c;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rv_uart_tx #(.CLK_FREQ_HZ(50_000_000), .BAUD_RATE(5_000_000), .DATA_WIDTH(8),
               .PARITY_MODE(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .in_data(in_data_a), .in_val(in_val_a),
    .in_rdy(in_rdy_a), .tx(tx_a), .busy(busy_a));

  rv_uart_tx #(.CLK_FREQ_HZ(50_000_000), .BAUD_RATE(5_000_000), .DATA_WIDTH(8),
               .PARITY_MODE(1), .STOP_BITS(1)) dut_b (
    .clk(clk), .rst(rst), .in_data(in_data_b), .in_val(in_val_b),
    .in_rdy(in_rdy_b), .tx(tx_b), .busy(busy_b));

  rv_uart_tx #(.CLK_FREQ_HZ(50_000_000), .BAUD_RATE(5_000_000), .DATA_WIDTH(8),
               .PARITY_MODE(2), .STOP_BITS(2)) dut_c (
    .clk(clk), .rst(rst), .in_data(in_data_c), .in_val(in_val_c),
    .in_rdy(in_rdy_c), .tx(tx_c), .busy(busy_c));

  // Line level k cycles after the accepting edge: bit index (k-1)/CPB of
  // start, data LSB first, optional parity, then stop/idle high.
  function automatic logic exp_tx(input logic [7:0] w, input int pm, input int k);
    int b;
    b = (k - 1) / CPB;
    if (b == 0) return 1'b0;
    if (b <= 8) return w[b-1];
    if (pm != 0 && b == 9) return (pm == 1) ? (^w) : ~(^w);
    return 1'b1;
  endfunction

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if (tx_a !== 1'b1 || busy_a !== 1'b0 || in_rdy_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_a tx=%b busy=%b rdy=%b required 1 0 0", tx_a, busy_a, in_rdy_a);
    end
    checks++;
    if (tx_b !== 1'b1 || busy_b !== 1'b0 || in_rdy_b !== 1'b0 ||
        tx_c !== 1'b1 || busy_c !== 1'b0 || in_rdy_c !== 1'b0) begin
      errors++;
      $display("FAIL reset_bc tx=%b%b busy=%b%b rdy=%b%b required 11 00 00",
               tx_b, tx_c, busy_b, busy_c, in_rdy_b, in_rdy_c);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (in_rdy_a !== 1'b1) begin
      errors++;
      $display("FAIL rdy_after_reset got %b required 1", in_rdy_a);
    end
    @(negedge clk);
  endtask

  // Call at a negedge with dut_a idle.
  task automatic test_single(input logic [7:0] w);
    checks++;
    if (in_rdy_a !== 1'b1) begin
      errors++;
      $display("FAIL single_rdy_pre got %b required 1", in_rdy_a);
    end
    in_data_a = w;
    in_val_a  = 1'b1;
    @(negedge clk);
    in_val_a  = 1'b0;
    in_data_a = 8'($urandom);
    checks++;
    if (busy_a !== 1'b1 || in_rdy_a !== 1'b0 || tx_a !== 1'b1) begin
      errors++;
      $display("FAIL single_accept busy=%b rdy=%b tx=%b required 1 0 1", busy_a, in_rdy_a, tx_a);
    end
    for (int k = 1; k <= 101; k++) begin
      @(negedge clk);
      checks++;
      if (tx_a !== exp_tx(w, 0, k)) begin
        errors++;
        $display("FAIL single_tx w=%h k=%0d got %b required %b", w, k, tx_a, exp_tx(w, 0, k));
      end
      checks++;
      if (busy_a !== (k < 100) || in_rdy_a !== (k >= 100)) begin
        errors++;
        $display("FAIL single_busy w=%h k=%0d busy=%b rdy=%b required %b %b",
                 w, k, busy_a, in_rdy_a, k < 100, k >= 100);
      end
    end
  endtask

  // Shared driver for the streaming scenarios: a FIFO with in_val held high
  // while it has words; when rnd is set in_data is scrambled whenever in_rdy is low.
  task automatic run_stream(input string name, input logic [7:0] words[3], input bit rnd);
    logic [7:0] q[$];
    int         xc[$];
    logic [7:0] xw[$];
    logic       tx_log[$];
    logic       xfer;
    for (int i = 0; i < 3; i++) q.push_back(words[i]);
    in_val_a  = 1'b1;
    in_data_a = q[0];
    for (int cyc = 0; cyc < 330; cyc++) begin
      xfer = in_val_a && in_rdy_a;
      @(posedge clk);
      if (xfer) begin
        xc.push_back(cyc);
        xw.push_back(in_data_a);
        void'(q.pop_front());
      end
      @(negedge clk);
      tx_log.push_back(tx_a);
      if (q.size() == 0) begin
        in_val_a = 1'b0;
      end else if (rnd && !in_rdy_a) begin
        in_data_a = 8'($urandom);
      end else begin
        in_data_a = q[0];
      end
    end
    in_val_a = 1'b0;
    checks++;
    if (xc.size() != 3) begin
      errors++;
      $display("FAIL %s_count got %0d required 3", name, xc.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (xc[i] != 101 * i) begin
          errors++;
          $display("FAIL %s_spacing i=%0d got %0d required %0d", name, i, xc[i], 101 * i);
        end
        checks++;
        if (xw[i] !== words[i]) begin
          errors++;
          $display("FAIL %s_word i=%0d got %h required %h", name, i, xw[i], words[i]);
        end
        for (int k = 1; k <= 101; k++) begin
          if (xc[i] + k < tx_log.size()) begin
            checks++;
            if (tx_log[xc[i] + k] !== exp_tx(words[i], 0, k)) begin
              errors++;
              $display("FAIL %s_tx i=%0d k=%0d got %b required %b",
                       name, i, k, tx_log[xc[i] + k], exp_tx(words[i], 0, k));
            end
          end
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0] w[3];
    w[0] = 8'h00;
    w[1] = 8'hFF;
    w[2] = 8'h3C;
    run_stream("b2b", w, 1'b0);
  endtask

  task automatic test_data_hold;
    logic [7:0] w[3];
    for (int i = 0; i < 3; i++) w[i] = 8'($urandom);
    run_stream("hold", w, 1'b1);
  endtask

  task automatic test_parity;
    in_data_b = 8'h07;
    in_data_c = 8'h07;
    in_val_b  = 1'b1;
    in_val_c  = 1'b1;
    @(negedge clk);
    in_val_b  = 1'b0;
    in_val_c  = 1'b0;
    in_data_b = 8'hFF;
    in_data_c = 8'hFF;
    for (int k = 1; k <= 121; k++) begin
      @(negedge clk);
      checks++;
      if (tx_b !== exp_tx(8'h07, 1, k) || busy_b !== (k < 110)) begin
        errors++;
        $display("FAIL parity_even k=%0d tx=%b busy=%b required %b %b",
                 k, tx_b, busy_b, exp_tx(8'h07, 1, k), k < 110);
      end
      checks++;
      if (tx_c !== exp_tx(8'h07, 2, k) || busy_c !== (k < 120)) begin
        errors++;
        $display("FAIL parity_odd_stop2 k=%0d tx=%b busy=%b required %b %b",
                 k, tx_c, busy_c, exp_tx(8'h07, 2, k), k < 120);
      end
      if (k == 95) begin
        checks++;
        if (tx_b !== 1'b1 || tx_c !== 1'b0) begin
          errors++;
          $display("FAIL parity_bit even=%b odd=%b required 1 0", tx_b, tx_c);
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    in_data_a = 8'hA5;
    in_val_a  = 1'b1;
    @(negedge clk);
    in_val_a = 1'b0;
    repeat (34) @(negedge clk);
    checks++;
    if (busy_a !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre busy got %b required 1", busy_a);
    end
    rst       = 1'b1;
    in_val_a  = 1'b1;
    in_data_a = 8'h5A;
    @(negedge clk);
    checks++;
    if (tx_a !== 1'b1 || busy_a !== 1'b0 || in_rdy_a !== 1'b0) begin
      errors++;
      $display("FAIL abort tx=%b busy=%b rdy=%b required 1 0 0", tx_a, busy_a, in_rdy_a);
    end
    rst      = 1'b0;
    in_val_a = 1'b0;
    @(negedge clk);
    checks++;
    if (busy_a !== 1'b0 || tx_a !== 1'b1) begin
      errors++;
      $display("FAIL abort_no_xfer busy=%b tx=%b required 0 1", busy_a, tx_a);
    end
    test_single(8'h5A);
  endtask

  task automatic test_idle;
    int bad;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      checks++;
      if (tx_a !== 1'b1 || busy_a !== 1'b0 || in_rdy_a !== 1'b1) begin
        errors++;
        bad++;
        if (bad <= 5)
          $display("FAIL idle cyc=%0d tx=%b busy=%b rdy=%b required 1 0 1",
                   i, tx_a, busy_a, in_rdy_a);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single(8'hA5);
    test_single(8'($urandom));
    test_back_to_back();
    test_parity();
    test_data_hold();
    test_reset_mid_frame();
    test_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
